// File: rtl/pc_unit_param_if.sv
// Fetch-side bundle for the parametrised PC unit.
// Master drives control and memory data; slave returns fetch address and status.
interface pc_unit_param_if #(
    parameter int unsigned WIDTH = 32
);
    logic             Stall;
    logic             BranchEn;
    logic [WIDTH-1:0] BranchAddr;
    logic             Rti;
    logic             IntReq;
    logic             LongInstr;
    logic [WIDTH-1:0] MemData;
    logic [WIDTH-1:0] PCOut;
    logic             VecFetch;
    logic             IntAck;
    logic             InIsr;

    modport master (
        output Stall, BranchEn, BranchAddr, Rti,
        output IntReq, LongInstr, MemData,
        input  PCOut, VecFetch, IntAck, InIsr
    );

    modport slave (
        input  Stall, BranchEn, BranchAddr, Rti,
        input  IntReq, LongInstr, MemData,
        output PCOut, VecFetch, IntAck, InIsr
    );
endinterface

// File: rtl/pc_unit_param.sv
// Program counter with stall, branch, vectored interrupt entry and return.
// Define PC_LONG_INSTR_EN to advance by 2*STEP when LongInstr is high.
module pc_unit_param #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_PC     = 32,
    parameter logic [WIDTH-1:0] INT_VEC_ADDR = 1,
    parameter int unsigned      STEP         = 1
) (
    input logic             Clk,
    input logic             Rst,
    pc_unit_param_if.slave  bus
);
    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_VEC  = 2'd1;
    localparam logic [1:0] S_LOAD = 2'd2;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] ret_q, ret_d;
    logic [1:0]       state_q, state_d;
    logic             in_isr_q, in_isr_d;
    logic             int_ack_q, int_ack_d;
    logic [WIDTH-1:0] inc;
    logic [WIDTH-1:0] seq;

`ifdef PC_LONG_INSTR_EN
    assign inc = bus.LongInstr ? WIDTH'(2 * STEP) : WIDTH'(STEP);
`else
    logic unused_long_instr;
    assign unused_long_instr = bus.LongInstr;
    assign inc = WIDTH'(STEP);
`endif

    assign seq = pc_q + inc;

    always_comb begin
        pc_d      = pc_q;
        ret_d     = ret_q;
        state_d   = state_q;
        in_isr_d  = in_isr_q;
        int_ack_d = 1'b0;
        case (state_q)
            S_VEC: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                pc_d      = bus.MemData;
                in_isr_d  = 1'b1;
                int_ack_d = 1'b1;
                state_d   = S_RUN;
            end
            default: begin
                // Priority order: return, flush, interrupt, stall, advance
                if (bus.Rti && in_isr_q) begin
                    pc_d     = ret_q;
                    in_isr_d = 1'b0;
                end else if (bus.BranchEn) begin
                    pc_d = bus.BranchAddr;
                end else if (bus.IntReq && !in_isr_q && !bus.Stall) begin
                    ret_d   = seq;
                    state_d = S_VEC;
                end else if (!bus.Stall) begin
                    pc_d = seq;
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            pc_q      <= RESET_PC;
            ret_q     <= '0;
            state_q   <= S_RUN;
            in_isr_q  <= 1'b0;
            int_ack_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            ret_q     <= ret_d;
            state_q   <= state_d;
            in_isr_q  <= in_isr_d;
            int_ack_q <= int_ack_d;
        end
    end

    assign bus.VecFetch = (state_q == S_VEC);
    assign bus.PCOut    = (state_q == S_VEC) ? INT_VEC_ADDR : pc_q;
    assign bus.IntAck   = int_ack_q;
    assign bus.InIsr    = in_isr_q;
endmodule
